mem_scan_reader: RTL and testbench
==================================

# mem_scan_reader

Read-side sequencer for the on-chip RAM. Walks an address window one word per `step` tick (typically the slow 1 Hz enable), issues single-cycle reads, absorbs the RAM's one-cycle read latency, and presents each word with its address on a valid/ready stream toward the display/output path. It is the consumer-side counterpart of the button-driven memory writer, and shares the RAM port through the existing address mux.

## Interface
Parameters:
- `ADDR_W`, 16, RAM address width
- `DATA_W`, 32, RAM word width

Ports:
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a scan; sampled only in IDLE
- `stop`  in  1  abort the scan; any state, next state IDLE
- `step`  in  1  one-cycle advance enable; sampled only in WAIT
- `first_addr`  in  ADDR_W  window start; latched on accepted `start`
- `last_addr`  in  ADDR_W  window end, inclusive; latched on accepted `start`
- `ram_addr`  out  ADDR_W  RAM read address
- `ram_rden`  out  1  RAM read strobe
- `ram_q`  in  DATA_W  RAM read data, valid the cycle after `ram_rden`
- `out_data`  out  DATA_W  registered word
- `out_addr`  out  ADDR_W  address of `out_data`
- `out_valid`  out  1  `out_data`/`out_addr` valid
- `out_ready`  in  1  consumer accepts when high with `out_valid`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of window

## Operation
- States: IDLE, ISSUE, CAPTURE, PRESENT, WAIT.
- IDLE: `start` -> latch `first_addr`/`last_addr`, `cur <= first_addr`, go ISSUE. `start` in any other state is ignored.
- ISSUE: `ram_rden=1`, `ram_addr=cur`; go CAPTURE.
- CAPTURE: `out_data <= ram_q`, `out_addr <= cur`, `out_valid <= 1`; go PRESENT.
- PRESENT: hold `out_valid`, `out_data`, `out_addr` stable until `out_valid && out_ready`. On accept: `out_valid <= 0`; if `cur == last_addr`, take the end-of-window action (see Configuration); else `cur <= cur + 1` (mod 2^ADDR_W), go WAIT.
- WAIT: `step` -> ISSUE. A `step` in any other state is dropped, not queued.
- Address arithmetic is modulo 2^ADDR_W. If `first_addr > last_addr`, the scan wraps through 0 until it reaches `last_addr`. If `first_addr == last_addr`, the window is one word.
- `ram_rden` is high only in ISSUE. `ram_addr` always drives `cur`.
- `stop`: next state IDLE, `out_valid <= 0`, no `done`. `stop` beats `start` and `step` in the same cycle.
- Reset values: state IDLE, `cur=0`, `ram_addr=0`, `ram_rden=0`, `out_data=0`, `out_addr=0`, `out_valid=0`, `busy=0`, `done=0`. Reset mid-scan behaves like `stop` and also clears the data registers.

## Timing
- `start` sampled at edge k: ISSUE after k, CAPTURE after k+1, `out_valid` high after k+2. The first word needs no `step`.
- Accept at edge m: WAIT after m. `step` sampled at edge n: `out_valid` is high again after n+2.
- Peak rate is one word per 4 cycles when `step` and `out_ready` are held high.
- `done` is high for exactly the cycle after the accepting edge of the `last_addr` word.
- `out_valid` never falls without an accept, except on `stop` or `reset`.

## Configuration
- `MEM_SCAN_READER_WRAP_EN` defined: on accepting the `last_addr` word, pulse `done`, set `cur <= first_addr`, go WAIT. Scanning repeats until `stop`, and `busy` stays high.
- Not defined: on accepting the `last_addr` word, pulse `done` and go IDLE (`busy` falls).

## Test plan
- Preload RAM[0..3] = 0xA0..0xA3; start with first=0, last=3; hold `out_ready=1`; send one `step` per 10 cycles -> words 0xA0..0xA3 with `out_addr` 0..3; first `out_valid` 2 cycles after `start`; `done` pulses once; `busy` falls (WRAP_EN off).
- Same setup with `out_ready` low for 5 cycles at word 1 -> `out_data`=0xA1 and `out_addr`=1 held stable; no word skipped; `step` pulses during PRESENT ignored.
- first=0xFFFE, last=0x0001 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, then `done`.
- `stop` asserted in CAPTURE, and separately `reset` in PRESENT -> `out_valid`=0 next cycle, IDLE, no `done`; with `reset`, `out_data`=0.
- WRAP_EN on, first=last=5, RAM[5]=0x55 -> 0x55 repeats after each `step`; `done` pulses on every accept; `busy` stays 1.
- `start` and `stop` in the same IDLE cycle -> stays IDLE, `ram_rden` never asserted.

Source files
------------

// File: rtl/mem_scan_reader_if.sv
// mem_scan_reader_if: RAM read port and output word stream of mem_scan_reader.
interface mem_scan_reader_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid;
   logic              out_ready;
   modport master (
      output ram_addr, ram_rden, out_data, out_addr, out_valid,
      input  ram_q, out_ready
   );
   modport slave (
      input  ram_addr, ram_rden, out_data, out_addr, out_valid,
      output ram_q, out_ready
   );
endinterface

// File: rtl/mem_scan_reader.sv
// mem_scan_reader: walks an address window one RAM word per step onto a valid/ready stream.
// Define MEM_SCAN_READER_WRAP_EN to restart at first_addr after the last word instead of going idle.
module mem_scan_reader #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              step,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              busy,
   output logic              done,
   mem_scan_reader_if.master bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, WAIT} state_t;
   state_t state, nxt, end_state;
   logic [ADDR_W-1:0] cur, last_q, reload;
   logic go, accept, at_last;
`ifdef MEM_SCAN_READER_WRAP_EN
   logic [ADDR_W-1:0] first_q;
   assign end_state = WAIT;
   assign reload = first_q;
`else
   assign end_state = IDLE;
   assign reload = cur;
`endif
   assign go = state == IDLE && start && !stop;
   assign accept = state == PRESENT && bus.out_valid && bus.out_ready && !stop;
   assign at_last = cur == last_q;
   assign bus.ram_addr = cur;
   assign bus.ram_rden = state == ISSUE;
   assign busy = state != IDLE;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? ISSUE : IDLE;
         ISSUE:   nxt = CAPTURE;
         CAPTURE: nxt = PRESENT;
         PRESENT: nxt = !accept ? PRESENT : at_last ? end_state : WAIT;
         WAIT:    nxt = step ? ISSUE : WAIT;
         default: nxt = IDLE;
      endcase
      if (stop) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cur <= '0;
         last_q <= '0;
`ifdef MEM_SCAN_READER_WRAP_EN
         first_q <= '0;
`endif
         bus.out_data <= '0;
         bus.out_addr <= '0;
         bus.out_valid <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= nxt;
         done <= accept && at_last;
         if (go) begin
            cur <= first_addr;
            last_q <= last_addr;
`ifdef MEM_SCAN_READER_WRAP_EN
            first_q <= first_addr;
`endif
         end else if (accept) begin
            cur <= at_last ? reload : cur + ADDR_W'(1);
         end
         // RAM data for cur arrives the cycle after ISSUE
         if (state == CAPTURE && !stop) begin
            bus.out_data <= bus.ram_q;
            bus.out_addr <= cur;
            bus.out_valid <= 1'b1;
         end else if (accept || stop) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_scan_reader.sv
// tb_mem_scan_reader: window vector table, hand-written corner sequences and randomized scans
// checked against the expected word sequence first..last of a RAM model.
module tb_mem_scan_reader;
`ifdef MEM_SCAN_READER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   logic clk = 0, reset = 1, start = 0, stop = 0, step = 0;
   logic [15:0] first_addr = 0, last_addr = 0;
   logic busy, done;
   logic [31:0] mem [0:65535];
   int passed = 0, total = 0, done_cnt = 0, rden_cnt = 0;

   typedef struct {
      logic [15:0] f;
      logic [15:0] l;
      int          n;
      logic [15:0] last_out;
      logic [31:0] first_data;
   } vec_t;
   vec_t tbl [5];

   mem_scan_reader_if #(.ADDR_W(16), .DATA_W(32)) bus ();
   mem_scan_reader #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
      .first_addr(first_addr), .last_addr(last_addr), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
   always @(posedge clk) begin
      if (done) done_cnt++;
      if (bus.ram_rden) rden_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_scan(input logic [15:0] f, input logic [15:0] l, input int n,
                           input int rdy_pct, input bit rnd_step,
                           output logic [31:0] first_data, output logic [15:0] last_got);
      logic [15:0] got_addr [$];
      logic [31:0] got_data [$];
      logic [15:0] ea, h_addr;
      logic [31:0] h_data;
      logic stall;
      int d0, words;
      d0 = done_cnt;
      @(negedge clk);
      first_addr = f;
      last_addr = l;
      start = 1;
      @(negedge clk);
      start = 0;
      chk("issue_rden", bus.ram_rden, 1);
      chk("issue_addr", bus.ram_addr, f);
      @(negedge clk);
      chk("capture_no_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("first_valid_latency", bus.out_valid, 1);
      stall = 0;
      words = 0;
      for (int cyc = 0; cyc < 3000 && words < n; cyc++) begin
         if (stall) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_addr", bus.out_addr, h_addr);
            chk("hold_data", bus.out_data, h_data);
         end
         bus.out_ready = $urandom_range(99) < rdy_pct;
         step = rnd_step ? $urandom_range(99) < 30 : cyc % 10 == 9;
         start = $urandom_range(99) < 10;
         first_addr = 16'($urandom);
         if (bus.out_valid && bus.out_ready) begin
            got_addr.push_back(bus.out_addr);
            got_data.push_back(bus.out_data);
            words++;
         end
         stall = bus.out_valid && !bus.out_ready;
         h_addr = bus.out_addr;
         h_data = bus.out_data;
         @(negedge clk);
      end
      step = 0;
      start = 0;
      repeat (3) @(negedge clk);
      chk("word_count", words, n);
      for (int i = 0; i < words; i++) begin
         ea = f + 16'(i);
         chk("word_addr", got_addr[i], ea);
         chk("word_data", got_data[i], mem[ea]);
      end
      chk("done_pulses", done_cnt - d0, 1);
      chk("busy_after_last", busy, WRAP);
      chk("valid_after_last", bus.out_valid, 0);
      first_data = words > 0 ? got_data[0] : 32'hx;
      last_got = words > 0 ? got_addr[words-1] : 16'hx;
      stop = 1;
      @(negedge clk);
      stop = 0;
      chk("idle_after_stop", busy, 0);
   endtask

   initial begin
      logic [15:0] a, f, l;
      logic [31:0] fd;
      logic [15:0] lg;
      int c, d0, r0, len;
      for (int i = 0; i < 65536; i++) begin
         a = 16'(i);
         mem[i] = {~a, a};
      end
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
      mem[5] = 32'h55;
      tbl[0] = '{16'h0000, 16'h0003, 4, 16'h0003, 32'h000000A0};
      tbl[1] = '{16'hFFFE, 16'h0001, 4, 16'h0001, 32'h0001FFFE};
      tbl[2] = '{16'h0005, 16'h0005, 1, 16'h0005, 32'h00000055};
      tbl[3] = '{16'hFFFF, 16'h0000, 2, 16'h0000, 32'h0000FFFF};
      tbl[4] = '{16'h0010, 16'h001F, 16, 16'h001F, 32'hFFEF0010};
      bus.out_ready = 1;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", bus.ram_rden, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      reset = 0;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         run_scan(tbl[v].f, tbl[v].l, tbl[v].n, 100, 0, fd, lg);
         chk("tbl_first_data", fd, tbl[v].first_data);
         chk("tbl_last_addr", lg, tbl[v].last_out);
      end

      // step and out_ready held high: word i accepted 3+4i edges after start
      @(negedge clk);
      bus.out_ready = 1;
      step = 1;
      first_addr = 0;
      last_addr = 3;
      start = 1;
      @(negedge clk);
      start = 0;
      c = 0;
      while (!done && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("peak_rate", c, 15);
      step = 0;
      stop = 1;
      @(negedge clk);
      stop = 0;
      chk("peak_idle", busy, 0);

      d0 = done_cnt;
      first_addr = 0;
      last_addr = 3;
      start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      stop = 1;
      @(negedge clk);
      stop = 0;
      chk("stop_capture_valid", bus.out_valid, 0);
      chk("stop_capture_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("stop_capture_stays", bus.out_valid, 0);
      chk("stop_no_done", done_cnt - d0, 0);

      bus.out_ready = 0;
      d0 = done_cnt;
      first_addr = 2;
      last_addr = 3;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      chk("present_data", bus.out_data, 32'hA2);
      chk("present_addr", bus.out_addr, 2);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("reset_mid_valid", bus.out_valid, 0);
      chk("reset_mid_data", bus.out_data, 0);
      chk("reset_mid_addr", bus.out_addr, 0);
      chk("reset_mid_busy", busy, 0);
      chk("reset_no_done", done_cnt - d0, 0);
      bus.out_ready = 1;

      r0 = rden_cnt;
      start = 1;
      stop = 1;
      @(negedge clk);
      start = 0;
      stop = 0;
      repeat (4) @(negedge clk);
      chk("start_stop_busy", busy, 0);
      chk("start_stop_rden", rden_cnt - r0, 0);

      for (int t = 0; t < 20; t++) begin
         f = 16'($urandom);
         len = $urandom_range(8, 1);
         l = f + 16'(len - 1);
         run_scan(f, l, len, 60, 1, fd, lg);
         chk("rnd_first_data", fd, mem[f]);
         chk("rnd_last_addr", lg, l);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
